// File: rtl/secure_scrub_fifo_if.sv
// Producer/consumer handshake, flush request and sweep status for secure_scrub_fifo.
// The FIFO takes the slave modport. The traffic source/sink takes the master modport.
interface secure_scrub_fifo_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
);
  logic                   in_valid;
  logic                   in_ready;
  logic [WIDTH-1:0]       in_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [WIDTH-1:0]       out_data;
  logic                   flush;
  logic [$clog2(DEPTH):0] count;
  logic                   scrub_busy;
  logic                   scrub_done;
  logic                   scrub_err;

  modport master (
    output in_valid, in_data, out_ready, flush,
    input  in_ready, out_valid, out_data, count, scrub_busy, scrub_done, scrub_err
  );

  modport slave (
    input  in_valid, in_data, out_ready, flush,
    output in_ready, out_valid, out_data, count, scrub_busy, scrub_done, scrub_err
  );
endinterface

// File: rtl/secure_scrub_fifo.sv
// Zeroizing FIFO: pops, reset and flush sweeps clear storage. Define SECURE_SCRUB_FIFO_VERIFY_EN to add a read-back verify pass.
// Data is visible 1 cycle after the push. in_ready drops when full, on flush, and for the whole sweep.
module secure_scrub_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  secure_scrub_fifo_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

`ifdef SECURE_SCRUB_FIFO_VERIFY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SCRUB = 2'd1, VERIFY = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SCRUB = 2'd1} state_t;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr, idx;
  logic [CW-1:0]    count_q;
  logic             done_q, done_d;
  logic             in_ready_c, out_valid_c, busy_c;
  logic             full, idx_last, push, pop;

  assign full     = (count_q == CW'(DEPTH));
  assign idx_last = (idx == LAST_IDX);
  assign push     = bus.in_valid && in_ready_c;
  assign pop      = out_valid_c && bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (bus.flush) state_d = SCRUB;
`ifdef SECURE_SCRUB_FIFO_VERIFY_EN
      SCRUB: if (idx_last) state_d = VERIFY;
      VERIFY: if (idx_last) state_d = IDLE;
`else
      SCRUB: if (idx_last) state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    busy_c      = 1'b0;
    done_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready_c  = !full && !bus.flush;
        out_valid_c = (count_q != '0) && !bus.flush;
      end
      SCRUB: begin
        busy_c = 1'b1;
`ifndef SECURE_SCRUB_FIFO_VERIFY_EN
        done_d = idx_last;
`endif
      end
`ifdef SECURE_SCRUB_FIFO_VERIFY_EN
      VERIFY: begin
        busy_c = 1'b1;
        done_d = idx_last;
      end
`endif
      default: ;
    endcase
  end

  // Push and pop never target the same entry: a full FIFO refuses the push.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      idx     <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= done_d;
      unique case (state_q)
        IDLE: begin
          if (bus.flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            idx     <= '0;
          end else begin
            if (push) begin
              mem[wr_ptr] <= bus.in_data;
              wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
              mem[rd_ptr] <= '0;
              rd_ptr      <= rd_ptr + 1'b1;
            end
            if (push && !pop)      count_q <= count_q + 1'b1;
            else if (pop && !push) count_q <= count_q - 1'b1;
          end
        end
        SCRUB: begin
          mem[idx] <= '0;
          idx      <= idx + 1'b1;
        end
`ifdef SECURE_SCRUB_FIFO_VERIFY_EN
        VERIFY: idx <= idx + 1'b1;
`endif
        default: ;
      endcase
    end
  end

`ifdef SECURE_SCRUB_FIFO_VERIFY_EN
  logic err_q;

  always_ff @(posedge clk) begin
    if (rst)                                         err_q <= 1'b0;
    else if (state_q == VERIFY && mem[idx] != '0)    err_q <= 1'b1;
  end

  assign bus.scrub_err = err_q;
`else
  assign bus.scrub_err = 1'b0;
`endif

  assign bus.in_ready   = in_ready_c;
  assign bus.out_valid  = out_valid_c;
  assign bus.out_data   = out_valid_c ? mem[rd_ptr] : '0;
  assign bus.count      = count_q;
  assign bus.scrub_busy = busy_c;
  assign bus.scrub_done = done_q;
endmodule

// File: tb/tb_secure_scrub_fifo.sv
// Bench for secure_scrub_fifo: vector table with a data scoreboard, then sweep/reset corner sequences.
module tb_secure_scrub_fifo;
  localparam int WIDTH = 32;
  localparam int DEPTH = 8;
`ifdef SECURE_SCRUB_FIFO_VERIFY_EN
  localparam int SWEEP = 2 * DEPTH;
`else
  localparam int SWEEP = DEPTH;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  secure_scrub_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();
  secure_scrub_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    bit          vld;
    logic [31:0] dat;
    bit          rdy;
    bit          ir;
    bit          ov;
    int          cnt;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void add(input bit vld, input logic [31:0] dat, input bit rdy,
                              input bit ir, input bit ov, input int cnt);
    vec_t v;
    v.vld = vld; v.dat = dat; v.rdy = rdy; v.ir = ir; v.ov = ov; v.cnt = cnt;
    vecs.push_back(v);
  endfunction

  // Drive at a negedge, let comb settle, then score any handshake that will occur on the coming edge.
  task automatic drive_eval(input bit vld, input logic [31:0] dat, input bit rdy, input bit fl);
    bus.in_valid  = vld;
    bus.in_data   = dat;
    bus.out_ready = rdy;
    bus.flush     = fl;
    #1;
    if (!bus.out_valid) chk("out_data_gated", bus.out_data, 32'h0);
    if (bus.flush && !bus.scrub_busy) exp_q.delete();
    if (bus.in_valid && bus.in_ready) exp_q.push_back(dat);
    if (bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_underflow: got %h expected nothing", bus.out_data);
      end else begin
        chk("sb_data", bus.out_data, exp_q.pop_front());
      end
    end
  endtask

  task automatic step(input bit vld, input logic [31:0] dat, input bit rdy, input bit fl);
    drive_eval(vld, dat, rdy, fl);
    @(negedge clk);
  endtask

  task automatic chk_mem_zero(input string name);
    for (int i = 0; i < DEPTH; i++) chk(name, dut.mem[i], 32'h0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0; bus.flush = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
  endtask

  // Starts right after the flush edge; counts busy cycles and the cycle index of the done pulse.
  task automatic sweep_watch(input bit flush_mid, output int busy_n, output int done_n,
                             output int done_at, output int ir_hi);
    busy_n = 0; done_n = 0; done_at = -1; ir_hi = 0;
    for (int c = 0; c < SWEEP + 4; c++) begin
      bus.flush = flush_mid && (c >= 1) && (c <= 3);
      #1;
      if (bus.scrub_busy) busy_n++;
      if (bus.scrub_busy && bus.in_ready) ir_hi++;
      if (bus.scrub_done) begin
        done_n++;
        done_at = c;
      end
      @(negedge clk);
    end
    bus.flush = 1'b0;
  endtask

  initial begin
    int b, d, da, ih;

    // Test 1: two words in, two out. Test 2: fill, full, steady push+pop across wrap, drain.
    add(1, 32'hA5A5A5A5, 0, 1, 0, 1);
    add(1, 32'h11111111, 0, 1, 1, 2);
    add(0, 32'h0,        1, 1, 1, 1);
    add(0, 32'h0,        1, 1, 1, 0);
    add(0, 32'h0,        1, 1, 0, 0);
    for (int i = 0; i < DEPTH; i++) add(1, 32'h100 + i, 0, 1, i > 0, i + 1);
    add(1, 32'hBAD0BAD0, 0, 0, 1, DEPTH);
    for (int i = 0; i < 4; i++) add(0, 32'h0, 1, i > 0, 1, DEPTH - 1 - i);
    for (int i = 0; i < 6; i++) add(1, 32'h200 + i, 1, 1, 1, 4);
    for (int i = 0; i < 4; i++) add(0, 32'h0, 1, 1, 1, 3 - i);
    add(0, 32'h0, 1, 1, 0, 0);

    @(negedge clk);
    do_reset();
    chk("rst_count",      bus.count,      0);
    chk("rst_in_ready",   bus.in_ready,   1);
    chk("rst_out_valid",  bus.out_valid,  0);
    chk("rst_out_data",   bus.out_data,   0);
    chk("rst_scrub_busy", bus.scrub_busy, 0);
    chk("rst_scrub_done", bus.scrub_done, 0);
    chk("rst_scrub_err",  bus.scrub_err,  0);
    chk_mem_zero("rst_mem");

    for (int i = 0; i < vecs.size(); i++) begin
      drive_eval(vecs[i].vld, vecs[i].dat, vecs[i].rdy, 1'b0);
      chk($sformatf("vec%0d_in_ready", i),  bus.in_ready,  vecs[i].ir);
      chk($sformatf("vec%0d_out_valid", i), bus.out_valid, vecs[i].ov);
      @(negedge clk);
      chk($sformatf("vec%0d_count", i), bus.count, vecs[i].cnt);
      if (i == 4) chk_mem_zero("pop_mem");
    end
    chk("table_sb_empty", exp_q.size(), 0);
    chk_mem_zero("drain_mem");

    // Test 3: flush with 5 entries held.
    for (int i = 0; i < 5; i++) step(1, 32'hC0DE0000 + i, 0, 0);
    drive_eval(1, 32'hFFFF0000, 1, 1);
    chk("flush_in_ready",  bus.in_ready,  0);
    chk("flush_out_valid", bus.out_valid, 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    chk("flush_count", bus.count, 0);
    sweep_watch(1'b0, b, d, da, ih);
    chk("sweep_busy_cycles", b,  SWEEP);
    chk("sweep_done_pulses", d,  1);
    chk("sweep_done_cycle",  da, SWEEP);
    chk("sweep_in_ready",    ih, 0);
    chk_mem_zero("sweep_mem");
    chk("sweep_scrub_err", bus.scrub_err, 0);

    // Test 5: empty pop attempt, then flush re-asserted mid-sweep must not stretch it.
    drive_eval(0, 32'h0, 1, 0);
    chk("empty_out_valid", bus.out_valid, 0);
    chk("empty_out_data",  bus.out_data,  0);
    @(negedge clk);
    chk("empty_count", bus.count, 0);
    for (int i = 0; i < 3; i++) step(1, 32'hE0E0E000 + i, 0, 0);
    step(0, 32'h0, 0, 1);
    sweep_watch(1'b1, b, d, da, ih);
    chk("midflush_busy_cycles", b,  SWEEP);
    chk("midflush_done_pulses", d,  1);
    chk("midflush_done_cycle",  da, SWEEP);
    chk_mem_zero("midflush_mem");

    // Test 4: reset at sweep cycle 3 with entries past the sweep front still holding data.
    for (int i = 0; i < 6; i++) step(1, 32'h5EC00000 + i, 0, 0);
    step(0, 32'h0, 0, 1);
    bus.flush = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    chk("abort_scrub_busy", bus.scrub_busy, 0);
    chk("abort_scrub_done", bus.scrub_done, 0);
    chk("abort_count",      bus.count,      0);
    chk("abort_in_ready",   bus.in_ready,   1);
    chk_mem_zero("abort_mem");
    d = 0;
    for (int c = 0; c < SWEEP + 2; c++) begin
      if (bus.scrub_done || bus.scrub_busy) d++;
      @(negedge clk);
    end
    chk("abort_no_done", d, 0);
    drive_eval(1, 32'h600DF00D, 0, 0);
    @(negedge clk);
    chk("abort_resume_valid", bus.out_valid, 1);
    chk("abort_resume_data",  bus.out_data,  32'h600DF00D);
    step(0, 32'h0, 1, 0);
    chk("abort_resume_count", bus.count, 0);

`ifdef SECURE_SCRUB_FIFO_VERIFY_EN
    // Test 6: corrupt an entry after the clear pass; verify pass must flag it and hold it.
    step(0, 32'h0, 0, 1);
    repeat (DEPTH) @(negedge clk);
    dut.mem[2] = 32'h0000DEAD;
    repeat (DEPTH + 2) @(negedge clk);
    chk("verify_err_set", bus.scrub_err, 1);
    repeat (4) @(negedge clk);
    chk("verify_err_sticky", bus.scrub_err, 1);
    do_reset();
    chk("verify_err_rst", bus.scrub_err, 0);
`else
    chk("no_verify_err", bus.scrub_err, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
